count_seq_arbiter: RTL and testbench
====================================

// Module: count_seq_arbiter
// PURPOSE
//  Shares one 4-bit loadable up/down counter between NREQ requesters.
//  Each job carries a start value, a target value and a direction.
//  The block arbitrates round-robin, loads the counter and lets it step until count==target.
//  It then reports completion (or timeout) to the owning requester.
//  Sits between the requester agents and the counter's din/load/ud/reset/count pins.
// PARAMETERS
//  DW    4          counter data width (din/count)
//  NREQ  2          number of requesters (>=2)
//  TMO   2**DW+1    max RUN cycles before a job is aborted with error
// PORTS
//  clock       in   1        single clock; all logic on posedge
//  reset       in   1        synchronous, active-high
//  req_valid   in   NREQ     job request per requester; held until accepted
//  req_ready   out  NREQ     one-hot accept; only in IDLE, only to the arbitration winner
//  req_start   in   NREQ*DW  start value, requester i at [i*DW +: DW]
//  req_target  in   NREQ*DW  target value, same packing
//  req_ud      in   NREQ     direction: 1=up, 0=down
//  done_valid  out  NREQ     one-cycle completion pulse to the owner
//  done_err    out  1        qualifies done_valid: 1 = timeout abort
//  busy        out  1        1 in any state other than IDLE
//  grant_id    out  $clog2(NREQ)  current or most recent owner index
//  cnt_reset   out  1        counter reset; equals reset
//  cnt_load    out  1        counter load strobe
//  cnt_din     out  DW       counter load value
//  cnt_ud      out  1        counter direction
//  cnt_count   in   DW       counter value, registered by the counter
// BEHAVIOUR
//  Counter model:
//   - load=1: count<=din at the next edge.
//   - Otherwise it steps +/-1 every edge per ud, with modulo 2**DW wrap.
//  Reset values:
//   - State IDLE, rr_ptr=0, grant_id=0, and all captured job registers cleared.
//   - req_ready=0, done_valid=0, done_err=0, busy=0.
//   - cnt_load=0, cnt_din=0, cnt_ud=1.
//   - cnt_reset=1 while reset is high.
//  Handshake: a transfer occurs when req_valid[i] && req_ready[i].
//   - The transfer captures start/target/ud of requester i into local registers.
//  Arbitration:
//   - In IDLE, search from rr_ptr upward (mod NREQ) for the first valid; that requester gets ready.
//   - On accept, rr_ptr <= winner+1 (mod NREQ).
//   - req_ready is combinational from state, req_valid and rr_ptr.
//  FSM (state and outputs registered unless noted):
//   - IDLE -> LOAD on accept.
//   - LOAD, 1 cycle:
//     - Drives cnt_load=1, cnt_din=start, cnt_ud=ud.
//     - Clears step counter; -> RUN.
//   - RUN:
//     - cnt_load=0, cnt_ud=ud.
//     - If cnt_count==target -> DONE, err=0.
//     - Else if step==TMO-1 -> DONE, err=1.
//     - Else step++.
//   - DONE, 1 cycle:
//     - done_valid[grant_id]=1, done_err=err; -> IDLE.
//  Latency:
//   - Accept edge to first RUN cycle is 2 cycles.
//   - start==target finishes in the first RUN cycle.
//   - Otherwise the job needs |target-start| steps in the job direction, mod 2**DW.
//  Wrap:
//   - Up from 14 to 1 takes 3 steps; down from 1 to 14 takes 3 steps.
//   - Counting is always in the requested direction, never the shortest path.
//  Idle counter:
//   - Outside LOAD the counter free-runs with the last cnt_ud.
//   - Only values observed in RUN are significant.
//  Step counter width: $clog2(TMO+1) bits; it never wraps.
//  Simultaneous events:
//   - A new req_valid during LOAD/RUN/DONE waits; no ready is given.
//   - A requester may re-request in the cycle after its done_valid.
//  Mid-operation reset:
//   - Aborts the job in the next cycle; no done_valid is issued.
//   - The FSM and all outputs return to their reset values.
// STRUCTURE
//  Package count_seq_pkg holds:
//   - typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} cs_state_e;
//   - localparam DW and typedef struct {start, target, ud} cs_job_t.
//  One sub-module: count_seq_rr_arb, a combinational round-robin winner search.
//   - Inputs: req_valid, rr_ptr. Outputs: one-hot grant, index.
//  The FSM, job registers and step counter live in the top module.
// TESTING
//  1. Req0 start=3, target=7, up:
//     - ready0 in cycle 0, cnt_load=1/din=3 in cycle 1.
//     - count 3,4,5,6,7 in RUN; done_valid[0] 1 cycle after count==7; err=0.
//  2. Req1 start=2, target=13, down (wrap):
//     - Count steps 2,1,0,15,14,13.
//     - done_valid[1] with err=0, 5 steps after load.
//  3. Req0 and req1 valid in the same cycle after reset:
//     - Req0 served first, then req1 immediately after DONE.
//     - Repeat both requests: req1 wins (rr_ptr=1), then req0.
//  4. start=9, target=9: first RUN cycle matches; done_valid in the cycle after LOAD+1; err=0.
//  5. Counter model stuck (cnt_count held at 0), target=5:
//     - After TMO RUN cycles, done_valid with done_err=1; FSM returns to IDLE.
//  6. Reset asserted on the 3rd RUN cycle of a job:
//     - Next cycle: state IDLE, busy=0, cnt_reset=1, no done_valid.
//     - After release, a new req is accepted normally.

Source files
------------

// File: rtl/count_seq_pkg.sv
// -----------------------------------------------------------------------------
// count_seq_pkg
// Shared types for the counter-sequencing arbiter.
//   DW          counter data width (start/target/count values)
//   cs_state_e  controller states
//   cs_job_t    one captured job: start value, target value, direction
// -----------------------------------------------------------------------------
package count_seq_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } cs_state_e;

  typedef struct packed {
    logic [DW-1:0] start;
    logic [DW-1:0] target;
    logic          ud;      // 1 = count up, 0 = count down
  } cs_job_t;

endpackage

// File: rtl/count_seq_arbiter_if.sv
// -----------------------------------------------------------------------------
// count_seq_arbiter_if
// Bundles the requester side and the counter side of count_seq_arbiter.
//   Requester side: req_valid/req_ready/req_start/req_target/req_ud in,
//                   done_valid/done_err/busy/grant_id back.
//   Counter side:   cnt_reset/cnt_load/cnt_din/cnt_ud out, cnt_count in.
// Modports:
//   slave  - the arbiter's view (drives ready/done/status and counter controls)
//   master - the environment's view (requesters plus the counter)
// -----------------------------------------------------------------------------
interface count_seq_arbiter_if
  import count_seq_pkg::*;
#(
  parameter int NREQ = 2
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_start;   // requester i at [i*DW +: DW]
  logic [NREQ*DW-1:0] req_target;  // same packing
  logic [NREQ-1:0]    req_ud;
  logic [NREQ-1:0]    done_valid;
  logic               done_err;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic               cnt_reset;
  logic               cnt_load;
  logic [DW-1:0]      cnt_din;
  logic               cnt_ud;
  logic [DW-1:0]      cnt_count;

  modport slave (
    input  req_valid, req_start, req_target, req_ud, cnt_count,
    output req_ready, done_valid, done_err, busy, grant_id,
           cnt_reset, cnt_load, cnt_din, cnt_ud
  );

  modport master (
    output req_valid, req_start, req_target, req_ud, cnt_count,
    input  req_ready, done_valid, done_err, busy, grant_id,
           cnt_reset, cnt_load, cnt_din, cnt_ud
  );

endinterface

// File: rtl/count_seq_rr_arb.sv
// -----------------------------------------------------------------------------
// count_seq_rr_arb
// Combinational round-robin winner search: starting at rr_ptr_i and moving
// upward (mod NREQ), the first asserted req_valid_i bit wins.
//   req_valid_i  in   NREQ  requests
//   rr_ptr_i     in   IW    highest-priority index this cycle
//   grant_o      out  NREQ  one-hot winner (all zero if no request)
//   grant_idx_o  out  IW    winner index (0 if no request)
//   any_o        out  1     at least one request present
// -----------------------------------------------------------------------------
module count_seq_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_o
);

  int unsigned idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(rr_ptr_i) + off) % NREQ;
      if (!any_o && req_valid_i[idx]) begin
        any_o       = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/count_seq_arbiter.sv
// -----------------------------------------------------------------------------
// count_seq_arbiter
// Shares one DW-bit loadable up/down counter between NREQ requesters. A job
// (start, target, direction) is accepted round-robin, loaded into the counter,
// and the counter is watched until it reaches the target or TMO run cycles
// elapse; the owner then receives a one-cycle done_valid (done_err on timeout).
// Ports:
//   clock  in  single clock, posedge
//   reset  in  synchronous, active-high; aborts any job without done_valid
//   bus    count_seq_arbiter_if.slave (requester handshake + counter pins)
// -----------------------------------------------------------------------------
module count_seq_arbiter
  import count_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TMO  = 2**DW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  count_seq_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(TMO + 1);

  cs_state_e       state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  cs_job_t         job_q, job_d;
  logic [SW-1:0]   step_q, step_d;
  logic [NREQ-1:0] done_valid_q, done_valid_d;
  logic            done_err_q, done_err_d;
  logic            busy_q, busy_d;
  logic            cnt_load_q, cnt_load_d;
  logic [DW-1:0]   cnt_din_q, cnt_din_d;
  logic            cnt_ud_q, cnt_ud_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  count_seq_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  // Ready is offered only while idle and never while reset is held, so a
  // transfer can never coincide with the reset edge.
  assign bus.req_ready = (state_q == IDLE && !reset) ? arb_grant : '0;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no branch
    // below can leave one unassigned and infer a latch.
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    job_d        = job_q;
    step_d       = step_q;
    done_valid_d = '0;
    done_err_d   = 1'b0;
    cnt_load_d   = 1'b0;
    cnt_din_d    = cnt_din_q;
    cnt_ud_d     = cnt_ud_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d      = LOAD;
          grant_id_d   = arb_idx;
          rr_ptr_d     = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          job_d.start  = bus.req_start[int'(arb_idx)*DW +: DW];
          job_d.target = bus.req_target[int'(arb_idx)*DW +: DW];
          job_d.ud     = bus.req_ud[arb_idx];
          // Registered outputs are computed from the next state so that the
          // load strobe is visible during the LOAD cycle itself.
          cnt_load_d   = 1'b1;
          cnt_din_d    = job_d.start;
          cnt_ud_d     = job_d.ud;
        end
      end
      LOAD: begin
        state_d  = RUN;
        step_d   = '0;
        cnt_ud_d = job_q.ud;
      end
      RUN: begin
        cnt_ud_d = job_q.ud;
        if (bus.cnt_count == job_q.target) begin
          state_d      = DONE;
          done_valid_d = NREQ'(1) << grant_id_q;
        end else if (step_q == SW'(TMO - 1)) begin
          state_d      = DONE;
          done_valid_d = NREQ'(1) << grant_id_q;
          done_err_d   = 1'b1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // values from before this edge, regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      job_q        <= '0;
      step_q       <= '0;
      done_valid_q <= '0;
      done_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      cnt_load_q   <= 1'b0;
      cnt_din_q    <= '0;
      cnt_ud_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      job_q        <= job_d;
      step_q       <= step_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      busy_q       <= busy_d;
      cnt_load_q   <= cnt_load_d;
      cnt_din_q    <= cnt_din_d;
      cnt_ud_q     <= cnt_ud_d;
    end
  end

  assign bus.done_valid = done_valid_q;
  assign bus.done_err   = done_err_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.cnt_reset  = reset;
  assign bus.cnt_load   = cnt_load_q;
  assign bus.cnt_din    = cnt_din_q;
  assign bus.cnt_ud     = cnt_ud_q;

endmodule

// File: tb/tb_count_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_count_seq_arbiter
// Drives count_seq_arbiter with a behavioural counter, a table of single jobs,
// hand-written multi-cycle sequences and a randomized multi-requester phase
// checked against a job-level timing model.
// -----------------------------------------------------------------------------
module tb_count_seq_arbiter;
  import count_seq_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 2**DW + 1;
  localparam int MOD  = 2**DW;

  logic clock;
  logic reset;
  logic stuck;
  logic [DW-1:0] tb_count;

  int n_pass;
  int n_total;

  count_seq_arbiter_if #(.NREQ(NREQ)) bus ();

  count_seq_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Counter being shared: load has priority, otherwise steps every edge.
  always @(posedge clock) begin
    if (bus.cnt_reset)    tb_count <= '0;
    else if (stuck)       tb_count <= '0;
    else if (bus.cnt_load) tb_count <= bus.cnt_din;
    else if (bus.cnt_ud)  tb_count <= tb_count + 1'b1;
    else                  tb_count <= tb_count - 1'b1;
  end
  assign bus.cnt_count = tb_count;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int id;
    int st;
    int tg;
    bit ud;
    bit stk;
    int lat;   // cycles from the accept cycle to the done_valid cycle
    bit err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int job_steps(input int st, input int tg, input bit ud);
    return ud ? (tg - st + MOD) % MOD : (st - tg + MOD) % MOD;
  endfunction

  task automatic set_job(input int id, input int st, input int tg, input bit ud);
    bus.req_start[id*DW +: DW]  = DW'(st);
    bus.req_target[id*DW +: DW] = DW'(tg);
    bus.req_ud[id]              = ud;
  endtask

  // Samples the current cycle, advancing one cycle at a time until a
  // done_valid is seen. lat counts the cycles advanced.
  task automatic wait_done(input string tag, output logic [NREQ-1:0] dv,
                           output logic de, output int lat, output int last_cnt);
    lat = 0; dv = '0; de = 1'b0; last_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      if (bus.done_valid != '0) begin
        dv = bus.done_valid;
        de = bus.done_err;
        break;
      end
      last_cnt = int'(tb_count);
      @(negedge clock); #1;
      lat++;
    end
    check({tag, " done seen"}, 32'(dv != '0), 1);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    stuck = 1'b0;
    bus.req_valid = '1;
    @(negedge clock); #1;
    check("rst req_ready",  bus.req_ready, 0);
    check("rst done_valid", bus.done_valid, 0);
    check("rst done_err",   bus.done_err, 0);
    check("rst busy",       bus.busy, 0);
    check("rst grant_id",   bus.grant_id, 0);
    check("rst cnt_reset",  bus.cnt_reset, 1);
    check("rst cnt_load",   bus.cnt_load, 0);
    check("rst cnt_din",    bus.cnt_din, 0);
    check("rst cnt_ud",     bus.cnt_ud, 1);
    @(negedge clock);
    reset = 1'b0;
    bus.req_valid = '0;
    #1;
    check("rst cnt_reset released", bus.cnt_reset, 0);
  endtask

  task automatic do_job(input string tag, input vec_t v);
    logic [NREQ-1:0] dv;
    logic de;
    int lat, last_cnt;
    bit got;
    @(negedge clock);
    stuck = v.stk;
    set_job(v.id, v.st, v.tg, v.ud);
    bus.req_valid = onehot(v.id);
    #1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready[v.id]) begin got = 1'b1; break; end
      @(negedge clock); #1;
    end
    check({tag, " accepted"}, 32'(got), 1);
    check({tag, " ready onehot"}, bus.req_ready, onehot(v.id));
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    check({tag, " cnt_load"}, bus.cnt_load, 1);
    check({tag, " cnt_din"},  bus.cnt_din, v.st);
    check({tag, " cnt_ud"},   bus.cnt_ud, v.ud);
    check({tag, " grant_id"}, bus.grant_id, v.id);
    check({tag, " busy"},     bus.busy, 1);
    wait_done(tag, dv, de, lat, last_cnt);
    check({tag, " latency"},    lat + 1, v.lat);
    check({tag, " done owner"}, dv, onehot(v.id));
    check({tag, " done_err"},   de, v.err);
    if (!v.err) check({tag, " final count"}, last_cnt, v.tg);
    @(negedge clock); #1;
    check({tag, " idle after"}, bus.busy, 0);
    stuck = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] dv, exp_dv, exp_rdy, pend;
    logic de;
    int lat, last_cnt, n_dv;
    int m_rr, m_owner, m_done_at, w, j;
    bit m_free;
    int r_st[NREQ], r_tg[NREQ];
    bit r_ud[NREQ];

    n_pass = 0; n_total = 0;
    reset = 1'b1; stuck = 1'b0;
    bus.req_valid = '0; bus.req_start = '0; bus.req_target = '0; bus.req_ud = '0;

    //           id st tg ud stk lat        err
    vecs[0] = '{0, 3,  7, 1'b1, 1'b0, 7,       1'b0};  // 4 steps up
    vecs[1] = '{1, 2, 13, 1'b0, 1'b0, 8,       1'b0};  // 5 steps down, wraps
    vecs[2] = '{0, 9,  9, 1'b1, 1'b0, 3,       1'b0};  // match in first RUN cycle
    vecs[3] = '{1, 14, 1, 1'b1, 1'b0, 6,       1'b0};  // up wrap, 3 steps
    vecs[4] = '{0, 1, 14, 1'b0, 1'b0, 6,       1'b0};  // down wrap, 3 steps
    vecs[5] = '{1, 5,  4, 1'b1, 1'b0, 18,      1'b0};  // long way round, 15 steps
    vecs[6] = '{0, 0, 15, 1'b0, 1'b0, 4,       1'b0};  // 1 step down
    vecs[7] = '{1, 2,  5, 1'b1, 1'b1, 2 + TMO, 1'b1};  // stuck counter -> timeout

    apply_reset();
    for (int i = 0; i < 8; i++) do_job($sformatf("vec%0d", i), vecs[i]);

    // Contention: both request together, rr pointer decides, re-request after done.
    apply_reset();
    @(negedge clock);
    set_job(0, 3, 4, 1'b1);
    set_job(1, 6, 8, 1'b1);
    bus.req_valid = 2'b11;
    #1;
    check("rr req0 first", bus.req_ready, 2'b01);
    @(negedge clock);
    bus.req_valid = 2'b10;
    #1;
    check("rr load req0 din", bus.cnt_din, 3);
    check("rr no ready busy", bus.req_ready, 0);
    wait_done("rr job0", dv, de, lat, last_cnt);
    check("rr job0 owner", dv, 2'b01);
    check("rr job0 latency", lat, 3);
    @(negedge clock);
    set_job(0, 9, 7, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    check("rr req1 after done", bus.req_ready, 2'b10);
    @(negedge clock);
    bus.req_valid = 2'b01;
    #1;
    check("rr grant req1", bus.grant_id, 1);
    check("rr load req1 din", bus.cnt_din, 6);
    wait_done("rr job1", dv, de, lat, last_cnt);
    check("rr job1 owner", dv, 2'b10);
    check("rr job1 latency", lat, 4);
    @(negedge clock); #1;
    check("rr req0 next", bus.req_ready, 2'b01);
    @(negedge clock);
    bus.req_valid = 2'b00;
    #1;
    check("rr load req0 again din", bus.cnt_din, 9);
    check("rr load req0 again ud", bus.cnt_ud, 0);
    wait_done("rr job2", dv, de, lat, last_cnt);
    check("rr job2 owner", dv, 2'b01);
    check("rr job2 latency", lat, 4);

    // Reset on the third RUN cycle aborts the job silently.
    apply_reset();
    @(negedge clock);
    set_job(0, 0, 10, 1'b1);
    bus.req_valid = 2'b01;
    #1;
    check("abort accepted", bus.req_ready, 2'b01);
    @(negedge clock); bus.req_valid = '0; #1;  // LOAD
    @(negedge clock); #1;                      // RUN 1
    @(negedge clock); #1;                      // RUN 2
    @(negedge clock); reset = 1'b1; #1;        // RUN 3 with reset
    check("abort busy before edge", bus.busy, 1);
    @(negedge clock); #1;
    check("abort busy", bus.busy, 0);
    check("abort cnt_reset", bus.cnt_reset, 1);
    check("abort no done", bus.done_valid, 0);
    check("abort cnt_load", bus.cnt_load, 0);
    check("abort cnt_ud", bus.cnt_ud, 1);
    @(negedge clock); reset = 1'b0;
    n_dv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock); #1;
      if (bus.done_valid != '0) n_dv++;
    end
    check("abort no late done", n_dv, 0);
    do_job("post-abort", '{1, 4, 6, 1'b1, 1'b0, 5, 1'b0});

    // Randomized traffic against a job-level timing model.
    apply_reset();
    m_free = 1'b1; m_rr = 0; m_owner = 0; m_done_at = -1; pend = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          r_st[i] = int'($urandom_range(0, MOD - 1));
          r_tg[i] = int'($urandom_range(0, MOD - 1));
          r_ud[i] = 1'($urandom_range(0, 1));
          set_job(i, r_st[i], r_tg[i], r_ud[i]);
        end
      end
      bus.req_valid = pend;
      #1;
      exp_dv = (!m_free && m_done_at == cyc) ? onehot(m_owner) : '0;
      check("rand done_valid", bus.done_valid, exp_dv);
      check("rand done_err", bus.done_err, 0);
      w = -1;
      if (m_free) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_rr + k) % NREQ;
          if (w < 0 && pend[j]) w = j;
        end
      end
      exp_rdy = (w >= 0) ? onehot(w) : '0;
      check("rand req_ready", bus.req_ready, exp_rdy);
      if (w >= 0) begin
        pend[w]   = 1'b0;
        m_free    = 1'b0;
        m_owner   = w;
        m_rr      = (w + 1) % NREQ;
        m_done_at = cyc + 3 + job_steps(r_st[w], r_tg[w], r_ud[w]);
      end
      if (exp_dv != '0) m_free = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
